// File: rtl/framebuffer_arbiter_pkg.sv
// Shared display definitions: screen geometry and the framebuffer arbiter state encoding.
// Also imported by vga_controller so both blocks agree on the frame size.
package framebuffer_arbiter_pkg;

   localparam int DISP_WIDTH  = 640;
   localparam int DISP_HEIGHT = 480;

   typedef enum logic [0:0] {
      StIdle,
      StClear
   } fb_state_e;

endpackage

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads beat the frame clear, which beats
// the draw engine's one-entry write holding register.
module framebuffer_arbiter
   import framebuffer_arbiter_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DISP_WIDTH,
   parameter int SCREEN_HEIGHT = DISP_HEIGHT,
   parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vga_rd_en,
   input  logic [ADDR_WIDTH-1:0] vga_addr,
   output logic                  vga_pixel,
   input  logic                  frame_pulse,
   input  logic                  clear_en,
   input  logic                  wr_valid,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  wr_data,
   output logic                  wr_ready,
   output logic                  fb_en,
   output logic                  fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic                  fb_wdata,
   input  logic                  fb_rdata,
   output logic                  clearing,
   output logic                  clear_done,
   output logic                  overrun
);

   localparam int unsigned NumPix = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPix - 1);

   fb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
   logic                  hold_data_q, hold_data_d;
   logic                  overrun_q, overrun_d;
   logic                  wr_in_range;

   assign wr_ready    = !hold_valid_q && (state_q == StIdle);
   assign clearing    = (state_q == StClear);
   assign overrun     = overrun_q;
   assign vga_pixel   = fb_rdata;
   assign wr_in_range = (32'(wr_addr) < NumPix);

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      hold_valid_d = hold_valid_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      overrun_d    = overrun_q;
      fb_en        = 1'b0;
      fb_we        = 1'b0;
      fb_addr      = '0;
      fb_wdata     = 1'b0;
      clear_done   = 1'b0;

      if (vga_rd_en) begin
         fb_en   = 1'b1;
         fb_addr = vga_addr;
      end

      unique case (state_q)
         StIdle: begin
            if (!vga_rd_en && hold_valid_q) begin
               fb_en        = 1'b1;
               fb_we        = 1'b1;
               fb_addr      = hold_addr_q;
               fb_wdata     = hold_data_q;
               hold_valid_d = 1'b0;
            end
            if (frame_pulse && clear_en) begin
               state_d   = StClear;
               clr_cnt_d = '0;
            end
         end
         StClear: begin
            if (frame_pulse && clear_en) begin
               overrun_d = 1'b1;
            end
            // The counter only advances on cycles the clear actually owns the RAM.
            if (!vga_rd_en) begin
               fb_en    = 1'b1;
               fb_we    = 1'b1;
               fb_addr  = clr_cnt_q;
               fb_wdata = 1'b0;
               if (clr_cnt_q == LastAddr) begin
                  clear_done = 1'b1;
                  state_d    = StIdle;
                  clr_cnt_d  = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Off-screen writes complete the handshake but are dropped here.
      if (wr_valid && wr_ready && wr_in_range) begin
         hold_valid_d = 1'b1;
         hold_addr_d  = wr_addr;
         hold_data_d  = wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         clr_cnt_q    <= '0;
         hold_valid_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_data_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         hold_valid_q <= hold_valid_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         overrun_q    <= overrun_d;
      end
   end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter on a reduced 60x30 screen with a behavioural RAM.
// A frame-level model predicts grants and RAM contents; a monitor checks read data.
module tb_framebuffer_arbiter;

   localparam int W    = 60;
   localparam int H    = 30;
   localparam int NPIX = W * H;
   localparam int AW   = $clog2(NPIX);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          vga_rd_en = 1'b0;
   logic [AW-1:0] vga_addr = '0;
   logic          vga_pixel;
   logic          frame_pulse = 1'b0;
   logic          clear_en = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic          wr_data = 1'b0;
   logic          wr_ready;
   logic          fb_en, fb_we, fb_wdata, clearing, clear_done, overrun;
   logic [AW-1:0] fb_addr;
   logic          fb_rdata = 1'b0;

   framebuffer_arbiter #(
      .SCREEN_WIDTH (W),
      .SCREEN_HEIGHT(H),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vga_rd_en  (vga_rd_en),
      .vga_addr   (vga_addr),
      .vga_pixel  (vga_pixel),
      .frame_pulse(frame_pulse),
      .clear_en   (clear_en),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .fb_en      (fb_en),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .fb_rdata   (fb_rdata),
      .clearing   (clearing),
      .clear_done (clear_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // External single-port RAM, one-cycle read latency.
   logic ram [2**AW];
   always @(posedge clk) begin
      if (fb_en) begin
         if (fb_we) ram[fb_addr] <= fb_wdata;
         else       fb_rdata     <= ram[fb_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: expected picture, clear progress, pending draw write, overrun flag.
   bit model_mem [2**AW];
   bit m_clear, m_pend, m_pend_data, m_overrun;
   int m_cnt, m_pend_addr;
   bit exp_q[$];
   bit s_clearing, s_done;

   logic rd_pend;
   always @(posedge clk or posedge reset) begin
      if (reset) rd_pend <= 1'b0;
      else       rd_pend <= vga_rd_en;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            if (exp_q.size() == 0) chk("vga_pixel_unexpected", 1, 0);
            else                   chk("vga_pixel", vga_pixel, exp_q.pop_front());
         end
      end
   end

   task automatic step(input bit rd, input int ra, input bit wv, input int wa, input bit wd,
                       input bit fp, input bit ce);
      bit exp_rdy, exp_en, exp_we, exp_wd, exp_done;
      int exp_addr;
      @(negedge clk);
      vga_rd_en   = rd;
      vga_addr    = AW'(ra);
      wr_valid    = wv;
      wr_addr     = AW'(wa);
      wr_data     = wd;
      frame_pulse = fp;
      clear_en    = ce;
      #1;
      exp_rdy  = !m_pend && !m_clear;
      exp_en   = 0;
      exp_we   = 0;
      exp_wd   = 0;
      exp_done = 0;
      exp_addr = 0;
      if (rd) begin
         exp_en   = 1;
         exp_addr = ra;
         exp_q.push_back(model_mem[ra]);
      end else if (m_clear) begin
         exp_en   = 1;
         exp_we   = 1;
         exp_addr = m_cnt;
         exp_done = (m_cnt == NPIX - 1);
      end else if (m_pend) begin
         exp_en   = 1;
         exp_we   = 1;
         exp_addr = m_pend_addr;
         exp_wd   = m_pend_data;
      end
      chk("wr_ready", wr_ready, exp_rdy);
      chk("clearing", clearing, m_clear);
      chk("clear_done", clear_done, exp_done);
      chk("overrun", overrun, m_overrun);
      chk("fb_en", fb_en, exp_en);
      chk("fb_we", fb_we, exp_we);
      if (exp_en) chk("fb_addr", fb_addr, exp_addr);
      if (exp_we) chk("fb_wdata", fb_wdata, exp_wd);
      s_clearing = clearing;
      s_done     = clear_done;

      if (exp_we) model_mem[exp_addr] = exp_wd;
      if (m_clear) begin
         if (fp && ce) m_overrun = 1;
         if (!rd) begin
            if (m_cnt == NPIX - 1) m_clear = 0;
            else                   m_cnt++;
         end
      end else begin
         if (!rd) m_pend = 0;
         if (fp && ce) begin
            m_clear = 1;
            m_cnt   = 0;
         end
      end
      if (wv && exp_rdy && wa < NPIX) begin
         m_pend      = 1;
         m_pend_addr = wa;
         m_pend_data = wd;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_clear_to(input int target);
      int guard = 0;
      step(0, 0, 0, 0, 0, 1, 1);
      while (m_cnt != target && guard < 4 * NPIX) begin
         idle();
         guard++;
      end
      chk("clear_reached_target", m_cnt, target);
   endtask

   initial begin
      int clr_cycles, done_pulses, nonzero, guard;
      bit nv;
      for (int i = 0; i < 2**AW; i++) begin
         ram[i]       = 1'($urandom);
         model_mem[i] = ram[i];
      end
      ram[5]       = 1'b0;
      model_mem[5] = 1'b0;

      // Reset values while held.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clearing", clearing, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_fb_en", fb_en, 0);
      chk("rst_wr_ready", wr_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      // Display read has the RAM combinationally; data one cycle later.
      step(1, 1234, 0, 0, 0, 0, 0);
      idle();

      // Draw write: ready drops for the drain cycle, RAM updated at that edge.
      step(0, 0, 1, 5, 1, 0, 0);
      idle();
      @(posedge clk);
      #1;
      chk("ram5_written", ram[5], 1);
      step(1, 5, 0, 0, 0, 0, 0);

      // Write held off by 10 back-to-back reads.
      nv = !model_mem[77];
      step(0, 0, 1, 77, nv, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 77, 0, 0, 0, 0, 0);
      idle();
      step(1, 77, 0, 0, 0, 0, 0);

      // Off-screen write is accepted but never reaches the RAM.
      step(0, 0, 1, NPIX + 3, 1, 0, 0);
      idle();

      // Full clear with the display idle.
      step(0, 0, 0, 0, 0, 1, 1);
      clr_cycles  = 0;
      done_pulses = 0;
      guard       = 0;
      do begin
         idle();
         clr_cycles  += int'(s_clearing);
         done_pulses += int'(s_done);
         guard++;
      end while (s_clearing && guard < NPIX + 20);
      chk("clear_cycles", clr_cycles, NPIX);
      chk("clear_done_pulses", done_pulses, 1);
      nonzero = 0;
      for (int i = 0; i < NPIX; i++) nonzero += int'(ram[i]);
      chk("ram_all_zero", nonzero, 0);

      // Second frame pulse mid-clear sets overrun; the clear carries on.
      run_clear_to(1000);
      step(0, 0, 0, 0, 0, 1, 1);
      idle();
      chk("overrun_sticky", overrun, 1);
      chk("counter_continues", m_cnt, 1002);
      guard = 0;
      while (m_clear && guard < 2 * NPIX) begin
         idle();
         guard++;
      end

      // Asynchronous reset mid-clear.
      run_clear_to(500);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_clearing", clearing, 0);
      chk("arst_overrun", overrun, 0);
      chk("arst_fb_en", fb_en, 0);
      chk("arst_clear_done", clear_done, 0);
      chk("arst_wr_ready", wr_ready, 1);
      m_clear   = 0;
      m_cnt     = 0;
      m_pend    = 0;
      m_overrun = 0;
      @(negedge clk);
      reset = 1'b0;
      idle();

      // Randomised traffic, including occasional frame pulses during and outside clears.
      for (int i = 0; i < 5000; i++) begin
         int ra, wa;
         bit rd, wv, fp;
         rd = ($urandom_range(0, 9) < 4);
         ra = $urandom_range(0, NPIX - 1);
         wv = $urandom_range(0, 1);
         wa = ($urandom_range(0, 9) == 0) ? $urandom_range(NPIX, 2**AW - 1)
                                          : $urandom_range(0, NPIX - 1);
         fp = ($urandom_range(0, 799) == 0);
         step(rd, ra, wv, wa, 1'($urandom), fp, 1'($urandom_range(0, 3) != 0));
      end
      idle();
      idle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
